// File: rtl/moxie_wb_pkg.sv
// Shared encodings and byte-lane helpers for the Moxie Wishbone port.
package moxie_wb_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Big-endian: byte offset o owns sel bit (dw/8 - 1 - o).
    function automatic logic [7:0] sel_mask(input logic [1:0] size, input logic [2:0] offset,
                                            input int dw);
        logic [7:0] m;
        int         nb;
        int         n;
        m  = 8'd0;
        nb = dw / 8;
        n  = 1 << size;
        for (int i = 0; i < 8; i++) begin
            if ((i >= int'(offset)) && (i < int'(offset) + n) && (i < nb)) begin
                m = m | (8'd1 << (nb - 1 - i));
            end
        end
        return m;
    endfunction

    function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size,
                                        input int dw);
        logic r;
        case (size)
            SZ_BYTE:  r = 1'b0;
            SZ_HALF:  r = addr[0];
            SZ_WORD:  r = |addr[1:0];
            SZ_DWORD: r = (dw == 32) || (|addr[2:0]);
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/moxie_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push and pop in one cycle are both honoured.
module moxie_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/moxie_wb_port.sv
// Wishbone classic master for the Moxie core: request FIFO, one bus cycle at a time,
// big-endian lane steering, error and timeout handling.
module moxie_wb_port
    import moxie_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    output logic            rsp_valid_o,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int EW = 1 + 2 + AW + DW;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW:0] TO_VAL = TIMEOUT[CW:0];

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CW-1:0]               r_cnt;
    logic [CW:0]                 w_cnt_inc;
    logic                        w_timeout;
    logic [1:0]                  r_size;
    logic [OB-1:0]               r_off;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(DEPTH+1)-1:0]  w_fifo_count_unused;
    logic [EW-1:0]               w_head;
    logic                        w_head_we;
    logic [1:0]                  w_head_size;
    logic [AW-1:0]               w_head_addr;
    logic [DW-1:0]               w_head_wdata;
    logic [OB-1:0]               w_off;
    logic                        w_mis;
    logic [7:0]                  w_sel8;
    logic [AW-1:0]               w_adr_al;
    logic [DW-1:0]               w_st_dat;
    int                          w_ld_nb;
    int                          w_ld_shift;
    logic [DW-1:0]               w_ld_mask;
    logic [DW-1:0]               w_ld_dat;

    assign req_ready_o = ~w_full;
    assign w_push      = req_valid_i & ~w_full;

    moxie_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_data  ({req_we_i, req_size_i, req_addr_i, req_wdata_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count_unused)
    );

    assign w_head_we    = w_head[EW-1];
    assign w_head_size  = w_head[EW-2 -: 2];
    assign w_head_addr  = w_head[DW +: AW];
    assign w_head_wdata = w_head[DW-1:0];
    assign w_off        = w_head_addr[OB-1:0];
    assign w_mis        = misaligned(w_head_addr[2:0], w_head_size, DW);
    assign w_sel8       = sel_mask(w_head_size, 3'(w_off), DW);
    assign w_adr_al     = {w_head_addr[AW-1:OB], {OB{1'b0}}};
    assign w_cnt_inc    = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
    assign w_timeout    = TO_EN && (w_cnt_inc == TO_VAL);

    // Store data: the right-justified operand is repeated across every lane.
    always_comb begin
        w_st_dat = w_head_wdata;
        case (w_head_size)
            SZ_BYTE: w_st_dat = {NB{w_head_wdata[7:0]}};
            SZ_HALF: w_st_dat = {(NB/2){w_head_wdata[15:0]}};
            SZ_WORD: w_st_dat = {(NB/4){w_head_wdata[31:0]}};
            default: w_st_dat = w_head_wdata;
        endcase
    end

    // Load data: move the addressed lanes down to bit 0 and clear the rest.
    always_comb begin
        w_ld_nb    = 1 << r_size;
        w_ld_shift = 8 * (NB - int'(r_off) - w_ld_nb);
        w_ld_mask  = {DW{1'b1}} >> (DW - 8 * w_ld_nb);
        w_ld_dat   = (wb_dat_i >> w_ld_shift) & w_ld_mask;
    end

    // Next-state logic and FIFO pop.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_mis ? ST_RESP : ST_BUS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wb_err_i || wb_ack_i || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_BUS;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus and response outputs; err takes priority over ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_adr_o    <= {AW{1'b0}};
            wb_dat_o    <= {DW{1'b0}};
            wb_sel_o    <= {NB{1'b0}};
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= {DW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_size      <= 2'd0;
            r_off       <= {OB{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop && w_mis) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= {DW{1'b0}};
                    end else if (w_pop) begin
                        wb_adr_o <= w_adr_al;
                        wb_dat_o <= w_st_dat;
                        wb_sel_o <= w_sel8[NB-1:0];
                        wb_we_o  <= w_head_we;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        r_cnt    <= {CW{1'b0}};
                        r_size   <= w_head_size;
                        r_off    <= w_off;
                    end else begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (wb_err_i || (!wb_ack_i && w_timeout)) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= {DW{1'b0}};
                    end else if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= w_ld_dat;
                    end else begin
                        r_cnt <= w_cnt_inc[CW-1:0];
                    end
                end
                ST_RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= {DW{1'b0}};
                end
                default: begin
                    wb_cyc_o    <= 1'b0;
                    wb_stb_o    <= 1'b0;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moxie_wb_port.sv
// Scoreboard bench for moxie_wb_port: directed cases plus randomized traffic.
module tb_moxie_wb_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 8;
    localparam int M_OK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    moxie_wb_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          waits;
        int          mode;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          dur;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    n_pass = 0;
    int    n_chk = 0;
    bit    saw_notready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave read data is a fixed function of the word address; 0x100 reads 0x11223344.
    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return ((a - 32'h100) * 32'h9E3779B1) ^ 32'h11223344;
    endfunction

    function automatic logic [3:0] exp_sel(input int n, input int off);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 0; k < 4; k++) if (k >= off && k < off + n) s[3-k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_dat(input int n, input logic [31:0] w);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < 4; k++) d[31-8*k -: 8] = w[8*(n-1-(k%n)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] d, input int n, input int off);
        logic [31:0] r;
        r = 32'd0;
        for (int j = 0; j < n; j++) r = (r << 8) | {24'd0, d[31-8*(off+j) -: 8]};
        return r;
    endfunction

    task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input int mode);
        exp_t  e;
        plan_t p;
        bit    mis;
        int    n, off;
        logic [31:0] al;
        n   = 1 << size;
        off = int'(addr[1:0]);
        al  = {addr[31:2], 2'b00};
        mis = (size == 2'd3) || ((addr % n) != 0);
        e.err    = mis || (mode != M_OK);
        e.chk_rd = e.err || !we;
        e.rd     = 32'd0;
        if (!e.err && !we) e.rd = exp_rd(slv_data(al), n, off);
        p.waits = waits; p.mode = mode; p.adr = al; p.we = we;
        p.sel = 4'd0; p.dat = 32'd0;
        if (!mis) begin
            p.sel = exp_sel(n, off);
            p.dat = exp_dat(n, wdata);
        end
        p.dur = (mode == M_NONE) ? TIMEOUT : waits + 1;
        req_we_i = we; req_size_i = size; req_addr_i = addr; req_wdata_i = wdata;
        req_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready_o) break;
            saw_notready = 1'b1;
        end
        if (!req_ready_o) chk("req_ready_timeout", req_ready_o, 1);
        exp_q.push_back(e);
        if (!mis) plan_q.push_back(p);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Slave model: plays back each bus cycle's plan and checks the cycle against it.
    plan_t cur;
    int    run;
    bit    active;
    logic [36:0] snap;
    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'd0; active = 1'b0; run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                active = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end else if (wb_stb_o) begin
                if (!active) begin
                    chk("stb_expected", plan_q.size() != 0, 1);
                    if (plan_q.size() != 0) begin
                        cur = plan_q.pop_front();
                        chk("bus_adr", wb_adr_o, cur.adr);
                        chk("bus_sel", wb_sel_o, cur.sel);
                        chk("bus_we", wb_we_o, cur.we);
                        if (cur.we) chk("bus_wdat", wb_dat_o, cur.dat);
                    end else begin
                        cur.waits = 0; cur.mode = M_OK; cur.dur = 1;
                    end
                    snap = {wb_adr_o, wb_sel_o, wb_we_o};
                    active = 1'b1; run = 0;
                end else begin
                    chk("bus_stable", {wb_adr_o, wb_sel_o, wb_we_o}, snap);
                end
                chk("cyc_with_stb", wb_cyc_o, 1);
                run++;
                wb_dat_i = slv_data(wb_adr_o);
                wb_ack_i = (run == cur.waits + 1) && (cur.mode == M_OK || cur.mode == M_BOTH);
                wb_err_i = (run == cur.waits + 1) && (cur.mode == M_ERR || cur.mode == M_BOTH);
            end else begin
                if (active) begin
                    chk("stb_cycles", run, cur.dur);
                    active = 1'b0;
                end
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid_o pulse.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni && rsp_valid_o) begin
                chk("rsp_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_err", rsp_err_o, mon_e.err);
                    if (mon_e.chk_rd) chk("rsp_rdata", rsp_rdata_o, mon_e.rd);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; saw_notready = 1'b0;
        #12;
        chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst_bus", {wb_adr_o, wb_dat_o, wb_sel_o}, 0);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
        chk("rst_ready", req_ready_o, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        send(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 2, M_OK);
        send(1'b0, 2'd0, 32'h103, 32'h0, 0, M_OK);
        send(1'b0, 2'd1, 32'h102, 32'h0, 1, M_OK);
        wait_idle();

        send(1'b0, 2'd2, 32'h102, 32'h0, 0, M_OK);
        @(negedge clk);
        chk("mis_rsp_early", rsp_valid_o, 0);
        @(negedge clk);
        chk("mis_rsp_edge2", rsp_valid_o, 1);
        chk("mis_no_cyc", wb_cyc_o, 0);
        wait_idle();

        send(1'b0, 2'd2, 32'h104, 32'h0, 0, M_OK);
        @(negedge clk);
        @(negedge clk);
        chk("ld_lat_early", rsp_valid_o, 0);
        @(negedge clk);
        chk("ld_lat_3", rsp_valid_o, 1);
        wait_idle();

        send(1'b0, 2'd2, 32'h108, 32'h0, 0, M_NONE);
        send(1'b1, 2'd1, 32'h10E, 32'h0000CAFE, 1, M_OK);
        wait_idle();

        saw_notready = 1'b0;
        send(1'b1, 2'd2, 32'h110, 32'h01020304, 5, M_OK);
        for (int i = 0; i < 5; i++) send(1'b0, 2'(i % 3), 32'h114 + 32'(4 * i), 32'h0, 0, M_OK);
        chk("ready_deasserted_full", saw_notready, 1);
        wait_idle();

        send(1'b0, 2'd2, 32'h120, 32'h0, 1, M_BOTH);
        send(1'b1, 2'd0, 32'h125, 32'h000000A5, 0, M_ERR);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 32'h200 + 32'($urandom_range(0, 63)), $urandom,
                 int'($urandom_range(0, 3)),
                 (r == 0) ? M_ERR : (r == 1) ? M_BOTH : (r == 2) ? M_NONE : M_OK);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        send(1'b0, 2'd2, 32'h300, 32'h0, 0, M_NONE);
        send(1'b1, 2'd2, 32'h304, 32'h12345678, 0, M_OK);
        for (int i = 0; i < 20; i++) begin
            if (wb_stb_o) break;
            @(negedge clk);
        end
        chk("stb_before_reset", wb_stb_o, 1);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        chk("post_rst_ready", req_ready_o, 1);
        repeat (12) @(negedge clk);
        chk("post_rst_idle", {wb_cyc_o, rsp_valid_o}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
